// File: rtl/apb_req_arbiter.sv
// APB master that shares one APB slave between NUM_REQ local requesters.
// Round-robin grant in IDLE, SETUP/ACCESS sequencing, and a watchdog on pready.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pready,
  input  logic                           pslverr
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           grant_idx;
  logic [GW-1:0]           cand;
  logic                    grant_found;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [CW-1:0]           timeout_cnt;
  logic [CW-1:0]           cnt_next;
  logic                    timeout_hit;

  // Scan from the requester after the last winner, wrapping, so nobody starves.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == GW'(k)) begin
        sel_write = req_write[k];
        sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign cnt_next    = timeout_cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == CW'(TIMEOUT_CYCLES));

  // last_grant doubles as the owner of the transfer in flight.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      last_grant  <= GW'(NUM_REQ - 1);
      timeout_cnt <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      busy        <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            pwrite      <= sel_write;
            paddr       <= sel_addr;
            pwdata      <= sel_wdata;
            last_grant  <= grant_idx;
            psel        <= 1'b1;
            busy        <= 1'b1;
            timeout_cnt <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready || timeout_hit) begin
            rsp_valid[last_grant] <= 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            rsp_err   <= pready ? pslverr : 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            timeout_cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
